instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 ADDR_W, 10, width of the instruction-memory word address produced with each encoded word.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  mnemonic request valid.
REQ-005 in_ready  output  1  encoder can accept a request this cycle.
REQ-006 in_mnem  input  5  mnemonic code; the code table is in REQ-012.
REQ-007 in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift-amount fields.
REQ-008 in_imm  input  16  immediate or branch offset; in_target  input  26  jump target.
REQ-009 out_valid  output  1  encoded word valid; out_ready  input  1  consumer accepts the word.
REQ-010 out_word  output  32  encoded instruction; out_addr  output  ADDR_W  memory address for out_word.
REQ-011 addr_clr  input  1  synchronous address restart; err  output  1  illegal-mnemonic pulse; err_cnt  output  8  saturating illegal count.

Function
REQ-012 Mnemonic codes 0-11 SHALL be R-type (opcode 000000) with funct 32,34,42,36,31,30,37,38,29,39,40,8 in that order; codes 12-22 SHALL be opcodes 001100,001101,100011,101011,000010,000001,000100,000101,000011,001111,010000 in that order; codes 23-31 are illegal.
REQ-013 R-type packing SHALL be op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
REQ-014 Shamt SHALL be packed only for funct 31, 30 and 29, with rs forced to 0; for every other funct, shamt SHALL be 0.
REQ-015 Funct 8 SHALL pack rs only; rt, rd and shamt SHALL be 0.
REQ-016 Opcodes 000010 and 000011 SHALL pack op[31:26] and target[25:0].
REQ-017 All other legal opcodes SHALL pack op, rs, rt and imm[15:0].
REQ-018 Pipeline SHALL have two stages: S1 registers the request and looks up the code; S2 packs the word and holds the output register. out_valid SHALL rise 2 cycles after acceptance when there is no backpressure, and throughput SHALL be 1 word per cycle.
REQ-019 A request SHALL be accepted only when in_valid and in_ready are both 1; in_ready SHALL be !S1_valid OR S1 advances.
REQ-020 S1 SHALL advance when !out_valid OR out_ready.
REQ-021 While out_valid=1 and out_ready=0, out_word and out_addr SHALL hold stable, and no request SHALL be lost or duplicated.
REQ-022 An illegal code SHALL pass through S1 but SHALL NOT produce out_valid. It SHALL pulse err for exactly 1 cycle as it leaves S1, increment err_cnt (saturating at 255), and leave the address unchanged.
REQ-023 The address counter SHALL increment by 1 on each out handshake (out_valid AND out_ready) and SHALL wrap from 2^ADDR_W-1 to 0.
REQ-024 out_addr SHALL equal the counter value at the time the word enters S2.
REQ-025 On addr_clr=1, the counter SHALL become 0 on the next cycle, taking priority over a coincident handshake increment. A word already in S2 SHALL keep its captured address.
REQ-026 Back-to-back legal words SHALL receive consecutive addresses, including across the wrap.

Reset
REQ-027 While rst_n=0: in_ready=0, out_valid=0, out_word=0, out_addr=0, err=0, err_cnt=0, and both pipeline stages are empty.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight words without emitting them.
REQ-029 in_ready SHALL go to 1 in the first cycle after rst_n deasserts.

Structure
REQ-030 Mnemonic code constants, the opcode/funct table, format enum (R, R_SHIFT, R_JR, I, J) and the illegal-code bound SHALL reside in shared package risc_isa_pkg, also used by the decoder.
REQ-031 The combinational lookup (code to format, opcode, funct) SHALL be the single sub-module instr_enc_lut; the handshake, pipeline and counters SHALL stay in instr_encoder.

Verification
REQ-032 Code 0, rs=1, rt=2, rd=3 -> out_word=0x00221820, out_addr=0, out_valid 2 cycles after accept.
REQ-033 Code 14 (100011), rs=4, rt=5, imm=0x0010 -> 0x8C850010; then code 20 (000011), target=0x0000100 -> 0x0C000100 at addr 1.
REQ-034 Code 4 (funct 31), rs=7, rt=1, rd=2, shamt=4 -> 0x0001111F (rs forced to 0).
REQ-035 Code 25 -> no out_valid, err pulses 1 cycle, err_cnt=1, next legal word keeps the same address; 300 illegal codes -> err_cnt=255.
REQ-036 out_ready held at 0 for 5 cycles with 3 requests queued -> in_ready=0 once both stages are full, word held stable, all 3 emitted in order after release.
REQ-037 Counter preset to 1023 with ADDR_W=10 -> two words at addr 1023 then 0; addr_clr coincident with a handshake -> next word at addr 0.

Source files
------------

// File: rtl/risc_isa_pkg.sv
// Shared ISA definitions for the instruction encoder and decoder: mnemonic codes,
// opcode/funct tables, word formats and the legal-code bound.
package risc_isa_pkg;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_R_SHIFT,
        FMT_R_JR,
        FMT_I,
        FMT_J
    } fmt_e;

    localparam logic [4:0] MN_ADD  = 5'd0;
    localparam logic [4:0] MN_SUB  = 5'd1;
    localparam logic [4:0] MN_SLT  = 5'd2;
    localparam logic [4:0] MN_AND  = 5'd3;
    localparam logic [4:0] MN_SHL  = 5'd4;
    localparam logic [4:0] MN_SHR  = 5'd5;
    localparam logic [4:0] MN_OR   = 5'd6;
    localparam logic [4:0] MN_XOR  = 5'd7;
    localparam logic [4:0] MN_SHA  = 5'd8;
    localparam logic [4:0] MN_NOR  = 5'd9;
    localparam logic [4:0] MN_SEQ  = 5'd10;
    localparam logic [4:0] MN_JR   = 5'd11;
    localparam logic [4:0] MN_ANDI = 5'd12;
    localparam logic [4:0] MN_ORI  = 5'd13;
    localparam logic [4:0] MN_LW   = 5'd14;
    localparam logic [4:0] MN_SW   = 5'd15;
    localparam logic [4:0] MN_J    = 5'd16;
    localparam logic [4:0] MN_BLTZ = 5'd17;
    localparam logic [4:0] MN_BEQ  = 5'd18;
    localparam logic [4:0] MN_BNE  = 5'd19;
    localparam logic [4:0] MN_JAL  = 5'd20;
    localparam logic [4:0] MN_LUI  = 5'd21;
    localparam logic [4:0] MN_COP0 = 5'd22;

    // Codes below MN_FIRST_ITYPE are R-type; codes from MN_FIRST_ILLEGAL up are rejected.
    localparam logic [4:0] MN_FIRST_ITYPE   = 5'd12;
    localparam logic [4:0] MN_FIRST_ILLEGAL = 5'd23;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_SLT = 6'd42;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_SHL = 6'd31;
    localparam logic [5:0] FN_SHR = 6'd30;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_XOR = 6'd38;
    localparam logic [5:0] FN_SHA = 6'd29;
    localparam logic [5:0] FN_NOR = 6'd39;
    localparam logic [5:0] FN_SEQ = 6'd40;
    localparam logic [5:0] FN_JR  = 6'd8;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_COP0  = 6'b010000;

    // Request as captured by the first pipeline stage.
    typedef struct packed {
        logic [4:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [25:0] target;
    } enc_req_t;

    function automatic logic [5:0] funct_of(input logic [4:0] code);
        logic [5:0] fn;
        case (code)
            MN_ADD:  fn = FN_ADD;
            MN_SUB:  fn = FN_SUB;
            MN_SLT:  fn = FN_SLT;
            MN_AND:  fn = FN_AND;
            MN_SHL:  fn = FN_SHL;
            MN_SHR:  fn = FN_SHR;
            MN_OR:   fn = FN_OR;
            MN_XOR:  fn = FN_XOR;
            MN_SHA:  fn = FN_SHA;
            MN_NOR:  fn = FN_NOR;
            MN_SEQ:  fn = FN_SEQ;
            MN_JR:   fn = FN_JR;
            default: fn = 6'd0;
        endcase
        return fn;
    endfunction

    function automatic logic [5:0] opcode_of(input logic [4:0] code);
        logic [5:0] op;
        case (code)
            MN_ANDI: op = OP_ANDI;
            MN_ORI:  op = OP_ORI;
            MN_LW:   op = OP_LW;
            MN_SW:   op = OP_SW;
            MN_J:    op = OP_J;
            MN_BLTZ: op = OP_BLTZ;
            MN_BEQ:  op = OP_BEQ;
            MN_BNE:  op = OP_BNE;
            MN_JAL:  op = OP_JAL;
            MN_LUI:  op = OP_LUI;
            MN_COP0: op = OP_COP0;
            default: op = OP_RTYPE;
        endcase
        return op;
    endfunction

    function automatic fmt_e fmt_of(input logic [4:0] code);
        logic [5:0] fn;
        logic [5:0] op;
        fmt_e       fmt;
        fn = funct_of(code);
        op = opcode_of(code);
        if (code < MN_FIRST_ITYPE) begin
            if (fn == FN_SHL || fn == FN_SHR || fn == FN_SHA) fmt = FMT_R_SHIFT;
            else if (fn == FN_JR)                             fmt = FMT_R_JR;
            else                                              fmt = FMT_R;
        end else if (op == OP_J || op == OP_JAL) begin
            fmt = FMT_J;
        end else begin
            fmt = FMT_I;
        end
        return fmt;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bus of the instruction encoder.
// Both channels use valid/ready: a transfer happens on a rising clock edge where valid
// and ready are both 1; once valid is raised, the payload stays stable until that edge.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_mnem;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
        output out_ready,
        input  in_ready, out_valid, out_word, out_addr
    );

    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
        input  out_ready,
        output in_ready, out_valid, out_word, out_addr
    );
endinterface

// File: rtl/instr_enc_lut.sv
// Combinational mnemonic lookup: code to word format, opcode, funct and legality.
module instr_enc_lut
    import risc_isa_pkg::*;
(
    input  logic [4:0] mnem_i,
    output fmt_e       fmt_o,
    output logic [5:0] opcode_o,
    output logic [5:0] funct_o,
    output logic       illegal_o
);

    always_comb begin
        fmt_o     = fmt_of(mnem_i);
        opcode_o  = opcode_of(mnem_i);
        funct_o   = funct_of(mnem_i);
        illegal_o = (mnem_i >= MN_FIRST_ILLEGAL);
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage instruction encoder: S1 registers a request and looks it up, S2 packs and
// holds the 32-bit word together with its instruction-memory address.
module instr_encoder
    import risc_isa_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            addr_clr,
    output logic            err,
    output logic [7:0]      err_cnt,
    instr_encoder_if.slave  bus
);

    logic              alive_q;
    logic              s1_valid_q, s1_valid_d;
    enc_req_t          s1_req_q, s1_req_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_word_q, out_word_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    fmt_e        lut_fmt;
    logic [5:0]  lut_opcode;
    logic [5:0]  lut_funct;
    logic        lut_illegal;
    logic [31:0] enc_word;
    enc_req_t    req_in;

    logic s1_adv;
    logic s1_load;
    logic in_fire;
    logic out_fire;

    instr_enc_lut u_lut (
        .mnem_i    (s1_req_q.mnem),
        .fmt_o     (lut_fmt),
        .opcode_o  (lut_opcode),
        .funct_o   (lut_funct),
        .illegal_o (lut_illegal)
    );

    assign req_in = {bus.in_mnem, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt,
                     bus.in_imm, bus.in_target};

    // alive_q keeps in_ready low until the first clock after reset is released.
    assign s1_adv       = !out_valid_q || bus.out_ready;
    assign s1_load      = !s1_valid_q || s1_adv;
    assign bus.in_ready = alive_q && s1_load;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = out_valid_q && bus.out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        if (s1_load) begin
            s1_valid_d = in_fire;
            if (in_fire) s1_req_d = req_in;
        end
    end

    always_comb begin
        enc_word = '0;
        case (lut_fmt)
            FMT_R:       enc_word = {lut_opcode, s1_req_q.rs, s1_req_q.rt, s1_req_q.rd,
                                     5'd0, lut_funct};
            FMT_R_SHIFT: enc_word = {lut_opcode, 5'd0, s1_req_q.rt, s1_req_q.rd,
                                     s1_req_q.shamt, lut_funct};
            FMT_R_JR:    enc_word = {lut_opcode, s1_req_q.rs, 15'd0, lut_funct};
            FMT_J:       enc_word = {lut_opcode, s1_req_q.target};
            default:     enc_word = {lut_opcode, s1_req_q.rs, s1_req_q.rt, s1_req_q.imm};
        endcase
    end

    // A word entering S2 takes the counter's next value, so a coincident handshake or
    // clear is already reflected in the address it carries.
    always_comb begin
        addr_d = addr_q;
        if (addr_clr)      addr_d = '0;
        else if (out_fire) addr_d = addr_q + 1'b1;

        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_addr_d  = out_addr_q;
        if (s1_adv) begin
            out_valid_d = s1_valid_q && !lut_illegal;
            if (s1_valid_q && !lut_illegal) begin
                out_word_d = enc_word;
                out_addr_d = addr_d;
            end
        end

        err_d     = s1_valid_q && s1_adv && lut_illegal;
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_req_q    <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_addr_q  <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            alive_q     <= 1'b1;
            s1_valid_q  <= s1_valid_d;
            s1_req_q    <= s1_req_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_addr_q  <= out_addr_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_addr  = out_addr_q;
    assign err           = err_q;
    assign err_cnt       = err_cnt_q;

endmodule
